// File: rtl/i2s_leftjustified_rx_pkg.sv
// Shared constants, FSM encoding and small helpers for the left-justified
// serial audio receiver.
package i2s_leftjustified_rx_pkg;

    localparam int CH_BITS_DEF = 32;
    localparam int SAMPLE_W    = 24;
    localparam int TIMEOUT_DEF = 256;
    localparam int CNT_W       = 6;
    localparam int WD_W        = 9;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } rx_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Two-flop synchronizer bringing one asynchronous serial-bus line into MCLK_i.
module i2s_rx_sync (
    input  logic MCLK_i,
    input  logic nRST_i,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Two-stage resynchronisation register
    always_ff @(posedge MCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/i2s_leftjustified_rx.sv
// Left-justified serial audio receiver: oversamples SCLK/LRCLK/SDATA on MCLK and
// emits a 24-bit left/right sample pair once per well-formed frame.
module i2s_leftjustified_rx
    import i2s_leftjustified_rx_pkg::*;
#(
    parameter int CH_BITS = CH_BITS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                MCLK_i,
    input  logic                nRST_i,
    input  logic                I2S_RX_en,
    input  logic                SCLK_i,
    input  logic                SDATA_i,
    input  logic                LRCLK_i,
    output logic [SAMPLE_W-1:0] PDATA_LEFT_o,
    output logic [SAMPLE_W-1:0] PDATA_RIGHT_o,
    output logic                PDATA_VALID_o,
    output logic                FRAME_ERR_o
);

    localparam logic [CNT_W-1:0] CH_MATCH = CNT_W'(CH_BITS);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SAMPLE_W);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

    logic                sclk_sync_s, sdata_sync_s, lrclk_sync_s;
    logic                sclk_prev_r, lrclk_prev_r;
    logic                sclk_rise_s, lr_change_s, timeout_s;
    logic [CNT_W-1:0]    cnt_r, cnt_next_s;
    logic [WD_W-1:0]     wd_r;
    logic [SAMPLE_W-1:0] shift_r, hold_r, pdata_left_r, pdata_right_r;
    logic                valid_r, err_r;
    logic                valid_n_s, err_n_s, latch_left_s, load_out_s;
    rx_state_e           state_r, state_n_s;

    i2s_rx_sync u_sync_sclk  (.MCLK_i(MCLK_i), .nRST_i(nRST_i), .async_in(SCLK_i),  .sync_out(sclk_sync_s));
    i2s_rx_sync u_sync_sdata (.MCLK_i(MCLK_i), .nRST_i(nRST_i), .async_in(SDATA_i), .sync_out(sdata_sync_s));
    i2s_rx_sync u_sync_lrclk (.MCLK_i(MCLK_i), .nRST_i(nRST_i), .async_in(LRCLK_i), .sync_out(lrclk_sync_s));

    assign sclk_rise_s = sclk_sync_s & ~sclk_prev_r;
    assign lr_change_s = sclk_rise_s & (lrclk_sync_s ^ lrclk_prev_r);
    assign timeout_s   = (wd_r == WD_MAX) && (state_r != ST_SYNC);

    // Post-sample bit count; restarts at 1 because the edge that reveals an LRCLK change carries the MSB
    always_comb begin
        cnt_next_s = cnt_r;
        if (sclk_rise_s) begin
            cnt_next_s = lr_change_s ? 6'd1 : sat_inc(cnt_r);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Edge history: SCLK every cycle, LRCLK only at SCLK rising edges
    always_ff @(posedge MCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            sclk_prev_r  <= 1'b0;
            lrclk_prev_r <= 1'b0;
        end else begin
            sclk_prev_r <= sclk_sync_s;
            if (sclk_rise_s) begin
                lrclk_prev_r <= lrclk_sync_s;
            end
        end
    end

    // Bit counter and SCLK watchdog
    always_ff @(posedge MCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            cnt_r <= 6'd0;
            wd_r  <= 9'd0;
        end else if (!I2S_RX_en) begin
            cnt_r <= 6'd0;
            wd_r  <= 9'd0;
        end else begin
            cnt_r <= cnt_next_s;
            if (sclk_rise_s) begin
                wd_r <= 9'd0;
            end else if (wd_r != WD_MAX) begin
                wd_r <= wd_r + 9'd1;
            end
        end
    end

    // Sample shifter keeps only the 24 MSBs; the left half waits in hold_r
    always_ff @(posedge MCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            shift_r <= 24'h000000;
            hold_r  <= 24'h000000;
        end else begin
            if (I2S_RX_en && sclk_rise_s && (cnt_next_s <= SHIFT_LAST)) begin
                shift_r <= {shift_r[SAMPLE_W-2:0], sdata_sync_s};
            end
            if (latch_left_s) begin
                hold_r <= shift_r;
            end
        end
    end

    // FSM state register
    always_ff @(posedge MCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next state; priority is disable, then timeout, then LRCLK change
    always_comb begin
        state_n_s    = state_r;
        err_n_s      = 1'b0;
        valid_n_s    = 1'b0;
        latch_left_s = 1'b0;
        load_out_s   = 1'b0;
        if (!I2S_RX_en) begin
            state_n_s = ST_SYNC;
        end else if (timeout_s) begin
            state_n_s = ST_SYNC;
            err_n_s   = 1'b1;
        end else if (lr_change_s) begin
            case (state_r)
                ST_SYNC: begin
                    if (lrclk_sync_s) begin
                        state_n_s = ST_LEFT;
                    end else begin
                        state_n_s = ST_SYNC;
                    end
                end
                ST_LEFT: begin
                    if (cnt_r == CH_MATCH) begin
                        latch_left_s = 1'b1;
                        state_n_s    = ST_RIGHT;
                    end else begin
                        err_n_s   = 1'b1;
                        state_n_s = ST_SYNC;
                    end
                end
                ST_RIGHT: begin
                    if (cnt_r == CH_MATCH) begin
                        load_out_s = 1'b1;
                        valid_n_s  = 1'b1;
                        state_n_s  = ST_LEFT;
                    end else begin
                        err_n_s   = 1'b1;
                        state_n_s = ST_SYNC;
                    end
                end
                default: begin
                    state_n_s = ST_SYNC;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // Registered outputs; sample pair only moves together with the valid pulse
    always_ff @(posedge MCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            pdata_left_r  <= 24'h000000;
            pdata_right_r <= 24'h000000;
            valid_r       <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            if (load_out_s) begin
                pdata_left_r  <= hold_r;
                pdata_right_r <= shift_r;
            end
            valid_r <= valid_n_s;
            err_r   <= err_n_s;
        end
    end

    assign PDATA_LEFT_o  = pdata_left_r;
    assign PDATA_RIGHT_o = pdata_right_r;
    assign PDATA_VALID_o = valid_r;
    assign FRAME_ERR_o   = err_r;

endmodule

// File: tb/tb_i2s_leftjustified_rx.sv
// Scoreboard bench for i2s_leftjustified_rx: SCLK = MCLK/8, 32-bit slots.
module tb_i2s_leftjustified_rx;

    logic        MCLK_i;
    logic        nRST_i;
    logic        I2S_RX_en;
    logic        SCLK_i;
    logic        SDATA_i;
    logic        LRCLK_i;
    logic [23:0] PDATA_LEFT_o;
    logic [23:0] PDATA_RIGHT_o;
    logic        PDATA_VALID_o;
    logic        FRAME_ERR_o;

    int          checks;
    int          failures;
    int          err_seen;
    int          valid_seen;
    logic [47:0] exp_q[$];
    logic [47:0] mon_pair;
    logic [47:0] prev_out;
    logic        prev_rst;

    i2s_leftjustified_rx #(.CH_BITS(32), .TIMEOUT(256)) dut (
        .MCLK_i       (MCLK_i),
        .nRST_i       (nRST_i),
        .I2S_RX_en    (I2S_RX_en),
        .SCLK_i       (SCLK_i),
        .SDATA_i      (SDATA_i),
        .LRCLK_i      (LRCLK_i),
        .PDATA_LEFT_o (PDATA_LEFT_o),
        .PDATA_RIGHT_o(PDATA_RIGHT_o),
        .PDATA_VALID_o(PDATA_VALID_o),
        .FRAME_ERR_o  (FRAME_ERR_o)
    );

    initial MCLK_i = 1'b0;
    always #5 MCLK_i = ~MCLK_i;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One SCLK period = 8 MCLK; data and LRCLK change with the falling edge
    task automatic send_bit(input logic lr, input logic d);
        @(negedge MCLK_i);
        SCLK_i  = 1'b0;
        LRCLK_i = lr;
        SDATA_i = d;
        repeat (4) @(negedge MCLK_i);
        SCLK_i = 1'b1;
        repeat (3) @(negedge MCLK_i);
    endtask

    task automatic send_bits(input logic lr, input int n);
        for (int i = 0; i < n; i++) send_bit(lr, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_slot(input logic lr, input logic [23:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < 24) send_bit(lr, v[23-i]);
            else        send_bit(lr, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int ln, input int rn);
        send_slot(1'b1, l, ln);
        send_slot(1'b0, r, rn);
    endtask

    task automatic push_and_send(input logic [23:0] l, input logic [23:0] r);
        exp_q.push_back({l, r});
        send_frame(l, r, 32, 32);
    endtask

    // Output monitor: pops the scoreboard on each valid pulse
    always @(negedge MCLK_i) begin
        if (nRST_i && PDATA_VALID_o) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 48'd1, 48'd0);
            end else begin
                mon_pair = exp_q.pop_front();
                chk("pdata_left", 48'(PDATA_LEFT_o), 48'(mon_pair[47:24]));
                chk("pdata_right", 48'(PDATA_RIGHT_o), 48'(mon_pair[23:0]));
            end
        end
        if (nRST_i && FRAME_ERR_o) err_seen++;
        if (nRST_i && prev_rst && !PDATA_VALID_o && ({PDATA_LEFT_o, PDATA_RIGHT_o} !== prev_out))
            chk("hold_without_valid", {PDATA_LEFT_o, PDATA_RIGHT_o}, prev_out);
        prev_out = {PDATA_LEFT_o, PDATA_RIGHT_o};
        prev_rst = nRST_i;
    end

    initial begin
        int e0;
        int v0;
        int pulses;
        int first_err;
        checks     = 0;
        failures   = 0;
        err_seen   = 0;
        valid_seen = 0;
        prev_out   = 48'd0;
        prev_rst   = 1'b0;
        nRST_i     = 1'b0;
        I2S_RX_en  = 1'b1;
        SCLK_i     = 1'b0;
        SDATA_i    = 1'b0;
        LRCLK_i    = 1'b0;
        repeat (5) @(negedge MCLK_i);
        chk("reset_left", 48'(PDATA_LEFT_o), 48'd0);
        chk("reset_right", 48'(PDATA_RIGHT_o), 48'd0);
        chk("reset_valid", 48'(PDATA_VALID_o), 48'd0);
        chk("reset_err", 48'(FRAME_ERR_o), 48'd0);
        nRST_i = 1'b1;

        // Normal frames, including signed extremes with random trailing bits
        send_bits(1'b0, 6);
        e0 = err_seen;
        repeat (3) push_and_send(24'h123456, 24'hA5F00F);
        repeat (2) push_and_send(24'h800000, 24'h7FFFFF);
        send_frame(24'h13579B, 24'h2468AC, 31, 32);
        chk("clean_then_short_left_err", 48'(err_seen - e0), 48'd1);
        push_and_send(24'h0F1E2D, 24'h3C4B5A);
        push_and_send(24'hC0FFEE, 24'h00BEEF);

        // SCLK stalls mid-left-slot
        send_bits(1'b1, 10);
        e0 = err_seen;
        pulses = 0;
        first_err = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge MCLK_i);
            if (FRAME_ERR_o) begin
                pulses++;
                if (first_err < 0) first_err = i + 3;
            end
        end
        chk("timeout_pulses", 48'(pulses), 48'd1);
        chk("timeout_latency_in_window", 48'((first_err >= 256) && (first_err <= 264)), 48'd1);
        chk("timeout_hold_left", 48'(PDATA_LEFT_o), 48'h0000_00C0FFEE);
        chk("timeout_hold_right", 48'(PDATA_RIGHT_o), 48'h0000_0000BEEF);
        send_bits(1'b0, 8);
        push_and_send(24'h55AA33, 24'h00FF01);

        // Reset during the right slot
        send_slot(1'b1, 24'h111111, 32);
        send_bits(1'b0, 10);
        chk("queue_empty_before_reset", 48'(exp_q.size()), 48'd0);
        @(negedge MCLK_i);
        nRST_i = 1'b0;
        #1;
        chk("midreset_left", 48'(PDATA_LEFT_o), 48'd0);
        chk("midreset_right", 48'(PDATA_RIGHT_o), 48'd0);
        repeat (3) @(negedge MCLK_i);
        nRST_i = 1'b1;
        send_bits(1'b0, 22);
        push_and_send(24'h654321, 24'hFEDCBA);

        // Disable for ~1000 MCLK while the bus keeps running
        send_bits(1'b1, 4);
        I2S_RX_en = 1'b0;
        v0 = valid_seen;
        e0 = err_seen;
        send_bits(1'b1, 28);
        send_frame(24'hABCDEF, 24'h123123, 32, 32);
        send_bits(1'b0, 33);
        I2S_RX_en = 1'b1;
        chk("disabled_valid_pulses", 48'(valid_seen - v0), 48'd0);
        chk("disabled_err_pulses", 48'(err_seen - e0), 48'd0);
        chk("disabled_hold_left", 48'(PDATA_LEFT_o), 48'h0000_00654321);
        send_bits(1'b0, 3);
        push_and_send(24'h7A7A7A, 24'h858585);
        push_and_send(24'h000001, 24'hFFFFFE);
        send_bits(1'b1, 4);
        repeat (20) @(negedge MCLK_i);
        chk("final_queue_drained", 48'(exp_q.size()), 48'd0);
        chk("final_no_err", 48'(err_seen - e0), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
